// File: rtl/dtw_result_sel_if.sv
// Word-stream handshake between dtw_core and the downstream sink FIFO.
// Master drives wren/data, slave returns full.
interface dtw_result_sel_if;
  logic        wren;
  logic        full;
  logic [31:0] data;

  modport master (output wren, output data, input full);
  modport slave  (input wren, input data, output full);
endinterface

// File: rtl/dtw_result_sel.sv
// Reduces each frame of DTW last-row costs to a (min cost, position) record.
// Define DTW_RESULT_SEL_SECOND_EN to also track and emit the second-best cost.
module dtw_result_sel #(
  parameter int COST_W = 32,
  parameter int POS_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             ref_len,
  dtw_result_sel_if.slave         in_if,
  dtw_result_sel_if.master        out_if,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_EMIT_COST = 3'd2,
    ST_EMIT_POS  = 3'd3
`ifdef DTW_RESULT_SEL_SECOND_EN
    , ST_EMIT_MIN2 = 3'd4
`endif
  } state_t;

  state_t              state_r;
  logic [31:0]         len_r;
  logic [31:0]         cnt_r;
  logic [COST_W-1:0]   min_r;
  logic [POS_W-1:0]    pos_r;
`ifdef DTW_RESULT_SEL_SECOND_EN
  logic [COST_W-1:0]   min2_r;
`endif
  logic                in_full_r;
  logic                out_wren_r;
  logic [31:0]         out_data_r;
  logic [15:0]         frame_cnt_r;

  logic                accept_s;
  logic [COST_W-1:0]   cost_s;
  logic [31:0]         first_len_s;
  logic                last_s;

  assign accept_s    = in_if.wren & ~in_full_r;
  assign cost_s      = in_if.data[COST_W-1:0];
  // A zero-length request still produces a well-formed one-word frame.
  assign first_len_s = (ref_len == 32'd0) ? 32'd1 : ref_len;
  assign last_s      = (cnt_r == (len_r - 32'd1));

  assign in_if.full   = in_full_r;
  assign out_if.wren  = out_wren_r;
  assign out_if.data  = out_data_r;
  assign frame_cnt    = frame_cnt_r;
  assign busy         = (state_r != ST_IDLE);

  // Frame scan / record emit FSM; in_full is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      len_r       <= 32'd0;
      cnt_r       <= 32'd0;
      min_r       <= {COST_W{1'b0}};
      pos_r       <= {POS_W{1'b0}};
`ifdef DTW_RESULT_SEL_SECOND_EN
      min2_r      <= {COST_W{1'b0}};
`endif
      in_full_r   <= 1'b0;
      out_wren_r  <= 1'b0;
      out_data_r  <= 32'd0;
      frame_cnt_r <= 16'd0;
    end else begin
      out_wren_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            len_r <= first_len_s;
            min_r <= cost_s;
            pos_r <= {POS_W{1'b0}};
            cnt_r <= 32'd1;
`ifdef DTW_RESULT_SEL_SECOND_EN
            min2_r <= {COST_W{1'b1}};
`endif
            if (first_len_s == 32'd1) begin
              state_r   <= ST_EMIT_COST;
              in_full_r <= 1'b1;
            end else begin
              state_r   <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (accept_s) begin
            // Strict compare so the earliest position wins a tie.
            if (cost_s < min_r) begin
              min_r <= cost_s;
              pos_r <= POS_W'(cnt_r);
`ifdef DTW_RESULT_SEL_SECOND_EN
              min2_r <= min_r;
`endif
            end
`ifdef DTW_RESULT_SEL_SECOND_EN
            else if (cost_s < min2_r) begin
              min2_r <= cost_s;
            end
`endif
            cnt_r <= cnt_r + 32'd1;
            if (last_s) begin
              state_r   <= ST_EMIT_COST;
              in_full_r <= 1'b1;
            end
          end
        end
        ST_EMIT_COST: begin
          if (!out_if.full) begin
            out_wren_r <= 1'b1;
            out_data_r <= 32'(min_r);
            state_r    <= ST_EMIT_POS;
          end
        end
        ST_EMIT_POS: begin
          if (!out_if.full) begin
            out_wren_r <= 1'b1;
            out_data_r <= 32'(pos_r);
`ifdef DTW_RESULT_SEL_SECOND_EN
            state_r    <= ST_EMIT_MIN2;
`else
            state_r     <= ST_IDLE;
            in_full_r   <= 1'b0;
            frame_cnt_r <= frame_cnt_r + 16'd1;
`endif
          end
        end
`ifdef DTW_RESULT_SEL_SECOND_EN
        ST_EMIT_MIN2: begin
          if (!out_if.full) begin
            out_wren_r  <= 1'b1;
            out_data_r  <= 32'(min2_r);
            state_r     <= ST_IDLE;
            in_full_r   <= 1'b0;
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end
        end
`endif
        default: begin
          state_r   <= ST_IDLE;
          in_full_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_result_sel.sv
// Table-driven scoreboard bench for dtw_result_sel (default and
// DTW_RESULT_SEL_SECOND_EN builds).
module tb_dtw_result_sel;

`ifdef DTW_RESULT_SEL_SECOND_EN
  localparam int STALL = 3;
`else
  localparam int STALL = 2;
`endif
  localparam int NV = 8;

  typedef struct {
    logic [31:0]       ref_len;
    int                n;
    logic [4:0][31:0]  w;
    logic [31:0]       e_cost;
    logic [31:0]       e_pos;
    logic [31:0]       e_min2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ref_len;
  logic [15:0] frame_cnt;
  logic        busy;

  dtw_result_sel_if in_if ();
  dtw_result_sel_if out_if ();

  dtw_result_sel dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_len   (ref_len),
    .in_if     (in_if),
    .out_if    (out_if),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          drop_cnt = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] rl, input int n,
                         input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                         input logic [31:0] c3, input logic [31:0] c4,
                         input logic [31:0] ec, input logic [31:0] ep, input logic [31:0] em2);
    vecs[i].ref_len = rl;
    vecs[i].n       = n;
    vecs[i].w[0] = c0; vecs[i].w[1] = c1; vecs[i].w[2] = c2;
    vecs[i].w[3] = c3; vecs[i].w[4] = c4;
    vecs[i].e_cost = ec;
    vecs[i].e_pos  = ep;
    vecs[i].e_min2 = em2;
  endtask

  task automatic push_rec(input logic [31:0] c, input logic [31:0] p, input logic [31:0] m2);
    exp_q.push_back(c);
    exp_q.push_back(p);
`ifdef DTW_RESULT_SEL_SECOND_EN
    exp_q.push_back(m2);
`endif
  endtask

  // Presents one word, never while in_full is high; ref_len is applied with it.
  task automatic send_word(input logic [31:0] d, input logic [31:0] rl);
    int b;
    b = 0;
    in_if.wren = 1'b0;
    while (in_if.full && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_full stuck at %0d expected 0", in_if.full);
    end
    in_if.wren = 1'b1;
    in_if.data = d;
    ref_len    = rl;
    @(posedge clk); #1;
    in_if.wren = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    push_rec(v.e_cost, v.e_pos, v.e_min2);
    for (int k = 0; k < v.n; k++)
      send_word(v.w[k], (k == 0) ? v.ref_len : 32'hFFFF_FFF0);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || busy) && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 100) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d words pending expected 0", exp_q.size());
    end
  endtask

  // Output monitor: pops the scoreboard on every result strobe.
  always @(negedge clk) begin
    logic [31:0] e;
    if (in_if.wren && in_if.full) drop_cnt++;
    if (out_if.wren) begin
      tests++;
      if (out_if.full) begin
        fails++;
        $display("FAIL wren_while_full: out_wren 1 with out_full 1 expected no strobe");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %h expected no word", out_if.data);
      end else begin
        e = exp_q.pop_front();
        if (out_if.data !== e) begin
          fails++;
          $display("FAIL out_word: got %h expected %h", out_if.data, e);
        end
      end
    end
  end

  initial begin
    int n;
    set_vec(0, 32'd4, 4, 32'd9, 32'd3, 32'd7, 32'd3, 32'd0, 32'd3, 32'd1, 32'd3);
    set_vec(1, 32'd1, 1, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    set_vec(2, 32'd0, 1, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    set_vec(3, 32'd2, 2, 32'd4, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd4);
    set_vec(4, 32'd2, 2, 32'd6, 32'd6, 32'd0, 32'd0, 32'd0, 32'd6, 32'd0, 32'd6);
    set_vec(5, 32'd5, 5, 32'd10, 32'd4, 32'd6, 32'd2, 32'd9, 32'd2, 32'd3, 32'd4);
    set_vec(6, 32'd3, 3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'd0, 32'd0,
            32'h8000_0000, 32'd1, 32'h8000_0001);
    set_vec(7, 32'd3, 3, 32'd5, 32'd2, 32'd8, 32'd0, 32'd0, 32'd2, 32'd1, 32'd5);

    rst_n       = 1'b0;
    ref_len     = 32'd0;
    in_if.wren  = 1'b0;
    in_if.data  = 32'd0;
    out_if.full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_full",   {31'd0, in_if.full},  32'd0);
    check("rst_out_wren",  {31'd0, out_if.wren}, 32'd0);
    check("rst_out_data",  out_if.data,          32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt},   32'd0);
    check("rst_busy",      {31'd0, busy},        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table frames run back-to-back with no idle gap.
    for (int i = 0; i < NV; i++) send_frame(vecs[i]);
    wait_drain();
    check("table_frame_cnt", {16'd0, frame_cnt}, NV);
    check("table_idle",      {31'd0, busy},      32'd0);

    // Latency and stall length after the last word.
    push_rec(32'd3, 32'd1, 32'd3);
    send_word(32'd9, 32'd4);
    send_word(32'd3, 32'hFFFF_FFF0);
    send_word(32'd7, 32'hFFFF_FFF0);
    send_word(32'd3, 32'hFFFF_FFF0);
    check("in_full_after_last", {31'd0, in_if.full},  32'd1);
    check("no_early_wren",      {31'd0, out_if.wren}, 32'd0);
    n = 0;
    while (in_if.full && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("first_word_latency", {31'd0, out_if.wren}, 32'd1);
    end
    check("stall_cycles", n, STALL);
    wait_drain();
    check("stall_frame_cnt", {16'd0, frame_cnt}, NV + 1);

    // Downstream full for 5 cycles starting at the first emit cycle.
    push_rec(32'd2, 32'd1, 32'd5);
    send_word(32'd5, 32'd3);
    send_word(32'd2, 32'hFFFF_FFF0);
    out_if.full = 1'b1;
    send_word(32'd8, 32'hFFFF_FFF0);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_full", {31'd0, in_if.full},  32'd1);
      check("hold_no_wren", {31'd0, out_if.wren}, 32'd0);
      @(posedge clk); #1;
    end
    out_if.full = 1'b0;
    check("hold_in_full_end", {31'd0, in_if.full}, 32'd1);
    wait_drain();
    check("hold_frame_cnt", {16'd0, frame_cnt}, NV + 2);

    // Asynchronous reset mid-scan aborts the frame.
    for (int k = 0; k < 4; k++) send_word(32'd20 + 32'(k), (k == 0) ? 32'd8 : 32'hFFFF_FFF0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_full",   {31'd0, in_if.full},  32'd0);
    check("arst_out_wren",  {31'd0, out_if.wren}, 32'd0);
    check("arst_out_data",  out_if.data,          32'd0);
    check("arst_frame_cnt", {16'd0, frame_cnt},   32'd0);
    check("arst_busy",      {31'd0, busy},        32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    push_rec(32'd2, 32'd1, 32'd7);
    send_word(32'd7, 32'd2);
    send_word(32'd2, 32'hFFFF_FFF0);
    wait_drain();
    check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    check("no_dropped_words",   drop_cnt,           32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
